ex_muldiv_ctrl: RTL

//  Multi-cycle multiply/divide sequencer beside the execute-stage ALU. The execute stage asserts

---
 rtl/ex_pkg.sv | 27 ++
 rtl/ex_muldiv_ctrl_if.sv | 24 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/ex_muldiv_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: muldiv op encodings,
// sequencer state enum and small op-decode helpers.
package ex_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // MULH and REM return the upper/remainder half
  function automatic logic sel_hi(input logic [1:0] op);
    return op == OP_MULH || op == OP_REM;
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Execute stage <-> muldiv sequencer bundle.
// master: execute stage (start/op/opa/opb out); slave: sequencer.
interface ex_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, opa, opb,
    input  stall, done, result, div_by_zero
  );

  modport slave (
    input  start, op, opa, opb,
    output stall, done, result, div_by_zero
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Ports: div (mode), hi/lo accumulator in, opd operand, hi_n/lo_n out.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opd,
  output logic [WIDTH:0]   hi_n,
  output logic [WIDTH-1:0] lo_n
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sft;
  logic [WIDTH:0] dif;
  logic           ge;

  // hi[WIDTH] is always 0 in multiply mode, so sum keeps the carry
  always_comb begin
    sum  = hi + (lo[0] ? {1'b0, opd} : '0);
    sft  = {hi[WIDTH-1:0], lo[WIDTH-1]};
    dif  = sft - {1'b0, opd};
    ge   = sft >= {1'b0, opd};
    hi_n = '0;
    lo_n = '0;
    unique case (1'b1)
      div: begin
        hi_n = ge ? dif : sft;
        lo_n = {lo[WIDTH-2:0], ge};
      end
      default: begin
        hi_n = {1'b0, sum[WIDTH:1]};
        lo_n = {sum[0], lo[WIDTH-1:1]};
      end
    endcase
  end
endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle mul/div sequencer beside the EX ALU; stalls pipe until done.
// Ports: clk, rst (sync, high), flush, bus (slave: start/op/opa/opb -> stall/done/result/div_by_zero).
module ex_muldiv_ctrl
  import ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  ex_muldiv_ctrl_if.slave bus
);
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opd_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] res_q;
  logic             dbz_q;
  logic [WIDTH:0]   hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             accept;
  logic             dz;
  logic             last;

  assign accept = state_q == ST_IDLE && bus.start && !flush;
  assign dz     = is_div(bus.op) && bus.opb == '0;
  assign last   = state_q == ST_RUN && cnt_q == CNT_W'(1);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div  (is_div(op_q)),
    .hi   (hi_q),
    .lo   (lo_q),
    .opd  (opd_q),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = dz ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (flush)     state_d = ST_IDLE;
        else if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opd_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= bus.op;
        opd_q <= bus.opb;
        hi_q  <= '0;
        lo_q  <= bus.opa;
        cnt_q <= CNT_W'(WIDTH);
        dbz_q <= dz;
        // divide by zero finishes immediately
        if (dz) res_q <= sel_hi(bus.op) ? bus.opa : '1;
      end else if (state_q == ST_RUN && !flush) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q - CNT_W'(1);
        if (last)
          res_q <= sel_hi(op_q) ? hi_n[WIDTH-1:0] : lo_n;
      end
    end
  end

  assign bus.stall       = accept || state_q == ST_RUN;
  assign bus.done        = state_q == ST_DONE && !flush;
  assign bus.result      = res_q;
  assign bus.div_by_zero = dbz_q;
endmodule
